// File: rtl/rgb2hsv.sv
// Three-stage pipelined RGB888 -> HSV (H 0..359, S/V 0..255) converter.
// Define RGB2HSV_ROUND_EN for round-half-up divisions instead of truncation.
module rgb2hsv (
  input  logic       clk_Image_Process,
  input  logic       Rst,
  input  logic [7:0] RGB_Data_R,
  input  logic [7:0] RGB_Data_G,
  input  logic [7:0] RGB_Data_B,
  input  logic       Data_Valid_In,
  output logic [8:0] HSV_Data_H,
  output logic [7:0] HSV_Data_S,
  output logic [7:0] HSV_Data_V,
  output logic       Data_Valid_Out,
  output logic [2:0] Delay_Num
);

  typedef enum logic [1:0] {
    SEC_R = 2'd0,
    SEC_G = 2'd1,
    SEC_B = 2'd2
  } sec_e;

  assign Delay_Num = 3'd3;

  logic       w_sel_r;
  logic       w_sel_g;
  sec_e       w_sec;
  logic [7:0] w_max;
  logic [7:0] w_min;
  logic [8:0] w_diff;

  assign w_sel_r = (RGB_Data_R >= RGB_Data_G)
                && (RGB_Data_R >= RGB_Data_B);
  assign w_sel_g = !w_sel_r && (RGB_Data_G >= RGB_Data_B);

  always_comb begin
    w_sec  = SEC_B;
    w_max  = RGB_Data_B;
    w_diff = {1'b0, RGB_Data_R} - {1'b0, RGB_Data_G};
    unique case (1'b1)
      w_sel_r: begin
        w_sec  = SEC_R;
        w_max  = RGB_Data_R;
        w_diff = {1'b0, RGB_Data_G} - {1'b0, RGB_Data_B};
      end
      w_sel_g: begin
        w_sec  = SEC_G;
        w_max  = RGB_Data_G;
        w_diff = {1'b0, RGB_Data_B} - {1'b0, RGB_Data_R};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_min = RGB_Data_R;
    if (RGB_Data_G < w_min) w_min = RGB_Data_G;
    if (RGB_Data_B < w_min) w_min = RGB_Data_B;
  end

  sec_e       r1_sec;
  logic [7:0] r1_max;
  logic [7:0] r1_delta;
  logic [8:0] r1_diff;
  logic       r1_vld;

  always_ff @(posedge clk_Image_Process or negedge Rst) begin
    if (!Rst) begin
      r1_sec   <= SEC_R;
      r1_max   <= 8'd0;
      r1_delta <= 8'd0;
      r1_diff  <= 9'd0;
      r1_vld   <= 1'b0;
    end else begin
      r1_sec   <= w_sec;
      r1_max   <= w_max;
      r1_delta <= w_max - w_min;
      r1_diff  <= w_diff;
      r1_vld   <= Data_Valid_In;
    end
  end

  // |diff| never exceeds delta, so q stays within 0..60
  logic [7:0]  w_absd;
  logic [13:0] w_qnum;
  logic [15:0] w_snum;
  logic [7:0]  w_qden;
  logic [7:0]  w_sden;
  logic [5:0]  w_q;
  logic [7:0]  w_s;

  assign w_absd = r1_diff[8] ? 8'(9'd0 - r1_diff) : r1_diff[7:0];
`ifdef RGB2HSV_ROUND_EN
  assign w_qnum = 14'(w_absd) * 14'd60 + 14'(r1_delta[7:1]);
  assign w_snum = 16'(r1_delta) * 16'd255 + 16'(r1_max[7:1]);
`else
  assign w_qnum = 14'(w_absd) * 14'd60;
  assign w_snum = 16'(r1_delta) * 16'd255;
`endif
  assign w_qden = (r1_delta == 8'd0) ? 8'd1 : r1_delta;
  assign w_sden = (r1_max == 8'd0) ? 8'd1 : r1_max;
  assign w_q    = 6'(w_qnum / 14'(w_qden));
  assign w_s    = 8'(w_snum / 16'(w_sden));

  sec_e       r2_sec;
  logic       r2_neg;
  logic       r2_grey;
  logic [5:0] r2_q;
  logic [7:0] r2_s;
  logic [7:0] r2_max;
  logic       r2_vld;

  always_ff @(posedge clk_Image_Process or negedge Rst) begin
    if (!Rst) begin
      r2_sec  <= SEC_R;
      r2_neg  <= 1'b0;
      r2_grey <= 1'b0;
      r2_q    <= 6'd0;
      r2_s    <= 8'd0;
      r2_max  <= 8'd0;
      r2_vld  <= 1'b0;
    end else begin
      r2_sec  <= r1_sec;
      r2_neg  <= r1_diff[8];
      r2_grey <= (r1_delta == 8'd0);
      r2_q    <= (r1_delta == 8'd0) ? 6'd0 : w_q;
      r2_s    <= (r1_max == 8'd0) ? 8'd0 : w_s;
      r2_max  <= r1_max;
      r2_vld  <= r1_vld;
    end
  end

  logic [9:0] w_h10;
  logic [9:0] w_q10;

  assign w_q10 = {4'd0, r2_q};

  always_comb begin
    w_h10 = 10'd0;
    unique case (r2_sec)
      SEC_R:   w_h10 = r2_neg ? 10'd360 - w_q10 : w_q10;
      SEC_G:   w_h10 = r2_neg ? 10'd120 - w_q10 : 10'd120 + w_q10;
      default: w_h10 = r2_neg ? 10'd240 - w_q10 : 10'd240 + w_q10;
    endcase
    if (r2_grey || (w_h10 >= 10'd360)) w_h10 = 10'd0;
  end

  logic [8:0] r_h;
  logic [7:0] r_s;
  logic [7:0] r_v;
  logic       r_vld;

  always_ff @(posedge clk_Image_Process or negedge Rst) begin
    if (!Rst) begin
      r_h   <= 9'd0;
      r_s   <= 8'd0;
      r_v   <= 8'd0;
      r_vld <= 1'b0;
    end else begin
      r_h   <= 9'(w_h10);
      r_s   <= r2_grey ? 8'd0 : r2_s;
      r_v   <= r2_max;
      r_vld <= r2_vld;
    end
  end

  assign HSV_Data_H     = r_h;
  assign HSV_Data_S     = r_s;
  assign HSV_Data_V     = r_v;
  assign Data_Valid_Out = r_vld;

endmodule

// File: tb/tb_rgb2hsv.sv
// Self-checking bench for rgb2hsv: directed vector table, toggled-valid
// stream, mid-stream reset and randomized pixels against an HSV model.
module tb_rgb2hsv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] r, g, b;
  logic       vin;
  logic [8:0] h_o;
  logic [7:0] s_o, v_o;
  logic       vout;
  logic [2:0] dly;

  always #5 clk = ~clk;

  rgb2hsv dut (
    .clk_Image_Process(clk),
    .Rst              (rst_n),
    .RGB_Data_R       (r),
    .RGB_Data_G       (g),
    .RGB_Data_B       (b),
    .Data_Valid_In    (vin),
    .HSV_Data_H       (h_o),
    .HSV_Data_S       (s_o),
    .HSV_Data_V       (v_o),
    .Data_Valid_Out   (vout),
    .Delay_Num        (dly)
  );

  typedef struct {
    int    h;
    int    s;
    int    v;
    bit    vld;
    string nm;
  } exp_t;

  typedef struct {
    int    r;
    int    g;
    int    b;
    int    h;
    int    s;
    int    v;
    string nm;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t pipe[3];
  vec_t tbl[10];

  function automatic exp_t model(int rr, int gg, int bb, bit vld,
                                 string nm);
    exp_t e;
    int mx, mn, d, df, base, q, num;
    mx = rr; if (gg > mx) mx = gg; if (bb > mx) mx = bb;
    mn = rr; if (gg < mn) mn = gg; if (bb < mn) mn = bb;
    d = mx - mn;
    e.v = mx; e.vld = vld; e.nm = nm; e.h = 0; e.s = 0;
    if (d != 0) begin
      if (rr >= gg && rr >= bb) begin base = 0;   df = gg - bb; end
      else if (gg >= bb)        begin base = 120; df = bb - rr; end
      else                      begin base = 240; df = rr - gg; end
      num = 60 * (df < 0 ? -df : df);
`ifdef RGB2HSV_ROUND_EN
      q   = (num + d / 2) / d;
      e.s = (255 * d + mx / 2) / mx;
`else
      q   = num / d;
      e.s = (255 * d) / mx;
`endif
      e.h = (base + (df < 0 ? -q : q) + 360) % 360;
    end
    return e;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.h = 0; e.s = 0; e.v = 0; e.vld = 1'b0; e.nm = "flushed";
    return e;
  endfunction

  task automatic check_now(input exp_t e, input string tag);
    n_tests++;
    if (vout !== e.vld || h_o !== 9'(e.h) ||
        s_o !== 8'(e.s) || v_o !== 8'(e.v)) begin
      n_fail++;
      $display("FAIL %s/%s: got H=%0d S=%0d V=%0d vld=%0b, want H=%0d S=%0d V=%0d vld=%0b",
               tag, e.nm, h_o, s_o, v_o, vout, e.h, e.s, e.v, e.vld);
    end
  endtask

  // drive one pixel, clock it, then compare the output 3 edges behind
  task automatic step(input int rr, input int gg, input int bb,
                      input bit vld, input exp_t e);
    r = 8'(rr); g = 8'(gg); b = 8'(bb); vin = vld;
    @(posedge clk); #1;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = e;
    check_now(pipe[2], "pipe");
  endtask

  task automatic rand_step(input bit vld);
    int rr, gg, bb;
    rr = int'($urandom_range(0, 255));
    gg = int'($urandom_range(0, 255));
    bb = int'($urandom_range(0, 255));
    if ($urandom_range(0, 7) == 0) gg = rr;
    if ($urandom_range(0, 7) == 0) bb = gg;
    step(rr, gg, bb, vld, model(rr, gg, bb, vld, "rand"));
  endtask

  initial begin
    logic [15:0] pat;
    exp_t        e;

    tbl[0] = '{255, 0,   0,   0,   255, 255, "prim_r"};
    tbl[1] = '{0,   255, 0,   120, 255, 255, "prim_g"};
    tbl[2] = '{0,   0,   255, 240, 255, 255, "prim_b"};
    tbl[3] = '{0,   0,   0,   0,   0,   0,   "grey_0"};
    tbl[4] = '{255, 255, 255, 0,   0,   255, "grey_255"};
    tbl[5] = '{128, 128, 128, 0,   0,   128, "grey_128"};
    tbl[6] = '{255, 0,   128, 330, 255, 255, "wrap_330"};
    tbl[7] = '{255, 0,   1,   0,   255, 255, "wrap_0"};
`ifdef RGB2HSV_ROUND_EN
    tbl[8] = '{200, 100, 51,  20,  190, 200, "round"};
`else
    tbl[8] = '{200, 100, 51,  19,  189, 200, "trunc"};
`endif
    tbl[9] = '{255, 255, 0,   60,  255, 255, "tie_rg"};

    for (int i = 0; i < 3; i++) pipe[i] = zero_exp();

    rst_n = 1'b0;
    r = 8'd77; g = 8'd33; b = 8'd200; vin = 1'b1;
    #12;
    check_now(zero_exp(), "reset");
    n_tests++;
    if (dly !== 3'd3) begin
      n_fail++;
      $display("FAIL delay_num: got %0d, want 3", dly);
    end
    r = 8'd0; g = 8'd0; b = 8'd0; vin = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      e = '{tbl[i].h, tbl[i].s, tbl[i].v, 1'b1, tbl[i].nm};
      step(tbl[i].r, tbl[i].g, tbl[i].b, 1'b1, e);
    end

    pat = 16'b1101_0011_1010_1101;
    for (int i = 0; i < 16; i++) rand_step(pat[i]);

    step(255, 0, 0, 1'b1, model(255, 0, 0, 1'b1, "pre_rst_r"));
    step(0, 255, 0, 1'b1, model(0, 255, 0, 1'b1, "pre_rst_g"));
    step(0, 0, 255, 1'b1, model(0, 0, 255, 1'b1, "pre_rst_b"));
    #2;
    rst_n = 1'b0;
    vin = 1'b0; r = 8'd10; g = 8'd20; b = 8'd30;
    #1;
    check_now(zero_exp(), "async_reset");
    for (int i = 0; i < 3; i++) pipe[i] = zero_exp();
    @(posedge clk); #1;
    check_now(zero_exp(), "held_reset");
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) rand_step(1'b0);

    for (int i = 0; i < 300; i++) rand_step(1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) rand_step(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
